gmm_subtract_weight_update: RTL and testbench
=============================================

// Module: gmm_subtract_weight_update
// PURPOSE
// - Stage directly downstream of the fp probability pipe in the GMM subtractor.
// - Consumes mega_data_t carrying p_max_idx and is_matched; decays every live cluster weight and rewards the matched one.
// - Inserts a new cluster when no match occurred (free slot), otherwise replaces the lowest-weight cluster.
// - 3-stage valid/ready pipeline; all fields not listed below pass through unchanged.
// PARAMETERS
// ALPHA_SHIFT  4     learning rate = 2^-ALPHA_SHIFT (1..7)
// INIT_W       16    8-bit weight given to an inserted/replaced cluster
// INIT_VAR     900   16-bit variance given to an inserted/replaced cluster
// PORTS
// clk        in   1                  clock
// rst        in   1                  synchronous, active-high reset
// snk_valid  in   1                  input beat valid
// snk_data   in   $bits(mega_data_t) record from probability pipe (p_max_idx valid)
// snk_ready  out  1                  stage accepts beat
// src_ready  in   1                  downstream accepts beat
// src_valid  out  1                  output beat valid
// src_data   out  $bits(mega_data_t) record with updated mem_w/mem_var/mem_color/clusters_num
// BEHAVIOUR
// - Reset: src_valid=0, src_data='0, all internal stage valids=0. Reset mid-stream drops in-flight beats.
// - Handshake per stage: stage_ready = next_ready | ~stage_valid; snk_ready = s1_ready. Beat moves on valid&&ready.
// - src_valid/src_data hold while src_valid && !src_ready. No beat is dropped, duplicated or reordered.
// - Latency 3 clk from snk accept to src_valid with src_ready held high; throughput 1 beat/clk.
// - N = snk_data.in.clusters_num (0..3). Only k < N is live; slots k >= N pass through untouched.
// - S1 (decay): for live k, w1[k] = w[k] - (w[k] >> ALPHA_SHIFT). 8-bit unsigned, no underflow possible.
// - S1 (reward): if is_matched && N != 0 && p_max_idx < N:
//   w1[p] = min(255, w1[p] + (256 >> ALPHA_SHIFT)).
// - is_matched with N == 0 is treated as unmatched. is_matched with p_max_idx >= N applies decay only, no reward, no insert.
// - S2 (insert/replace), only when treated as unmatched:
//   - N < 3: slot N gets mem_w=INIT_W, mem_var=INIT_VAR, mem_color=in.color; clusters_num=N+1.
//   - N == 3: target = index of min w1 over 0..2; ties go to the higher index. Target is overwritten as above; clusters_num stays 3.
// - S2 (matched): mem_color and mem_var are unchanged; mean/var refinement belongs to a later stage.
// - S3: output register. p_max_idx becomes the inserted/replaced index when unmatched; B, vars, w_sum, var_* and in pass through.
// - Arithmetic is purely integer; no floating point in this block.
// TESTING
// - N=3, w={100,50,20}, matched, p=1, ALPHA_SHIFT=4 -> w={94,63,19}; clusters_num=3; out 3 clk after accept.
// - N=1, w0=200, unmatched, in.color={10,20,30} -> w={188,16,-}; var1=900; color1={10,20,30}; clusters_num=2; p_max_idx=1.
// - N=3, w={40,8,8}, unmatched -> decay {38,8,8}; tie -> slot 2 replaced: w={38,8,16}; p_max_idx=2.
// - N=2, w1=250, matched p=1 -> 250-15+16 = 251; w1=255, matched p=1 -> 240+16 = 256 -> saturates to 255.
// - Random valid/ready toggling on 1000 beats -> output sequence matches reference model, no loss or reorder; src_data stable while stalled.
// - Assert rst with 3 beats in flight -> next cycle src_valid=0, snk_ready=1; no stale beat emerges afterwards.

Source files
------------

// File: rtl/gmm_subtract_weight_update.sv
// gmm_subtract_weight_update
//   Weight-update stage of the GMM background subtractor. Sits right after the
//   probability pipe. Every live cluster weight is decayed by 2^-ALPHA_SHIFT,
//   the matched cluster is rewarded, and when no match occurred a new cluster
//   is inserted into a free slot or written over the lowest-weight cluster.
//   Three-stage valid/ready pipeline:
//     S1 decay/reward, S2 insert/replace, S3 output register.
//
// Ports
//   clk        clock
//   rst        synchronous active-high reset (drops in-flight beats)
//   snk_valid  input beat valid
//   snk_data   mega_data_t record from the probability pipe
//   snk_ready  stage accepts a beat
//   src_ready  downstream accepts a beat
//   src_valid  output beat valid
//   src_data   record with updated mem_w/mem_var/mem_color/clusters_num

package gmm_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } color_t;

  typedef struct packed {
    color_t     color;
    logic [1:0] clusters_num;
  } in_t;

  typedef struct packed {
    in_t              in;
    logic [2:0][7:0]  mem_w;
    logic [2:0][15:0] mem_var;
    color_t [2:0]     mem_color;
    logic [1:0]       clusters_num;
    logic [1:0]       p_max_idx;
    logic             is_matched;
    logic [1:0]       b;
    logic [15:0]      vars;
    logic [9:0]       w_sum;
    logic [15:0]      var_min;
    logic [15:0]      var_max;
  } mega_data_t;

endpackage

module gmm_subtract_weight_update
  import gmm_pkg::*;
#(
  parameter int          ALPHA_SHIFT = 4,
  parameter logic [7:0]  INIT_W      = 8'd16,
  parameter logic [15:0] INIT_VAR    = 16'd900
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       snk_valid,
  input  mega_data_t snk_data,
  output logic       snk_ready,
  input  logic       src_ready,
  output logic       src_valid,
  output mega_data_t src_data
);

  // ALPHA_SHIFT >= 1 keeps the reward <= 128, so a 9-bit sum never wraps.
  localparam logic [8:0] REWARD = 9'(256 >> ALPHA_SHIFT);

  logic       s1_valid;
  logic       s1_insert;
  mega_data_t s1_data;
  logic       s1_ready;

  logic       s2_valid;
  logic       s2_insert;
  logic [1:0] s2_target;
  mega_data_t s2_data;
  logic       s2_ready;

  logic       s3_ready;

  assign s3_ready  = src_ready | ~src_valid;
  assign s2_ready  = s3_ready  | ~s2_valid;
  assign s1_ready  = s2_ready  | ~s1_valid;
  assign snk_ready = s1_ready;

  // ---------------------------------------------------------------- S1
  logic [1:0] s0_n;
  logic       s0_match_eff;
  logic       s0_reward;
  logic       s0_insert;
  logic [7:0] s0_dec;
  logic [8:0] s0_sum;
  mega_data_t s0_next;

  always_comb begin
    s0_next      = snk_data;
    s0_dec       = '0;
    s0_sum       = '0;
    s0_n         = snk_data.in.clusters_num;
    // A match against an empty model is meaningless; treat it as a miss.
    s0_match_eff = snk_data.is_matched && (s0_n != 2'd0);
    s0_reward    = s0_match_eff && (snk_data.p_max_idx < s0_n);
    // A match whose index is out of range still counts as matched: no insert.
    s0_insert    = !s0_match_eff;
    for (int k = 0; k < 3; k++) begin
      if (2'(k) < s0_n) begin
        s0_dec = snk_data.mem_w[k] - (snk_data.mem_w[k] >> ALPHA_SHIFT);
        if (s0_reward && (snk_data.p_max_idx == 2'(k))) begin
          s0_sum = {1'b0, s0_dec} + REWARD;
          s0_next.mem_w[k] = s0_sum[8] ? 8'hff : s0_sum[7:0];
        end else begin
          s0_next.mem_w[k] = s0_dec;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_insert <= 1'b0;
      s1_data   <= '0;
    end else if (s1_ready) begin
      s1_valid <= snk_valid;
      if (snk_valid) begin
        s1_data   <= s0_next;
        s1_insert <= s0_insert;
      end
    end
  end

  // ---------------------------------------------------------------- S2
  logic [1:0] s1_n;
  logic [1:0] s1_min_idx;
  logic [1:0] s1_target;
  mega_data_t s1_next;

  always_comb begin
    s1_next    = s1_data;
    s1_n       = s1_data.in.clusters_num;
    // Scan from the top with strict compares so ties resolve to the higher slot.
    s1_min_idx = 2'd2;
    if (s1_data.mem_w[1] < s1_data.mem_w[s1_min_idx]) s1_min_idx = 2'd1;
    if (s1_data.mem_w[0] < s1_data.mem_w[s1_min_idx]) s1_min_idx = 2'd0;
    s1_target  = (s1_n == 2'd3) ? s1_min_idx : s1_n;

    if (s1_insert) begin
      s1_next.mem_w[s1_target]     = INIT_W;
      s1_next.mem_var[s1_target]   = INIT_VAR;
      s1_next.mem_color[s1_target] = s1_data.in.color;
      s1_next.clusters_num         = (s1_n == 2'd3) ? 2'd3 : s1_n + 2'd1;
    end else begin
      s1_next.clusters_num = s1_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_insert <= 1'b0;
      s2_target <= '0;
      s2_data   <= '0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data   <= s1_next;
        s2_insert <= s1_insert;
        s2_target <= s1_target;
      end
    end
  end

  // ---------------------------------------------------------------- S3
  mega_data_t s2_next;

  always_comb begin
    s2_next = s2_data;
    if (s2_insert) s2_next.p_max_idx = s2_target;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_valid <= 1'b0;
      src_data  <= '0;
    end else if (s3_ready) begin
      src_valid <= s2_valid;
      if (s2_valid) src_data <= s2_next;
    end
  end

endmodule

// File: tb/tb_gmm_subtract_weight_update.sv
module tb_gmm_subtract_weight_update;
  import gmm_pkg::*;

  localparam int ALPHA    = 4;
  localparam int INIT_W   = 16;
  localparam int INIT_VAR = 900;
  localparam int NBEATS   = 1000;
  localparam int NVEC     = 7;

  logic       clk;
  logic       rst;
  logic       snk_valid;
  mega_data_t snk_data;
  logic       snk_ready;
  logic       src_ready;
  logic       src_valid;
  mega_data_t src_data;

  int n_cmp;
  int n_bad;

  gmm_subtract_weight_update #(
    .ALPHA_SHIFT(ALPHA),
    .INIT_W     (8'(INIT_W)),
    .INIT_VAR   (16'(INIT_VAR))
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .snk_valid(snk_valid),
    .snk_data (snk_data),
    .snk_ready(snk_ready),
    .src_ready(src_ready),
    .src_valid(src_valid),
    .src_data (src_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    mega_data_t din;
    mega_data_t dexp;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic check_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_data(input string nm, input mega_data_t act, input mega_data_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: the update rules written out with plain integers.
  function automatic mega_data_t model(input mega_data_t d);
    mega_data_t o;
    int n, p, t;
    int w [3];
    bit m;
    o = d;
    n = int'(d.in.clusters_num);
    p = int'(d.p_max_idx);
    m = d.is_matched && (n != 0);
    for (int k = 0; k < 3; k++) w[k] = int'(d.mem_w[k]);
    for (int k = 0; k < n; k++) w[k] = w[k] - w[k] / (1 << ALPHA);
    if (m && p < n) begin
      w[p] = w[p] + 256 / (1 << ALPHA);
      if (w[p] > 255) w[p] = 255;
    end
    if (!m) begin
      if (n < 3) t = n;
      else begin
        t = 0;
        for (int k = 1; k < 3; k++) if (w[k] <= w[t]) t = k;
      end
      w[t]           = INIT_W;
      o.mem_var[t]   = 16'(INIT_VAR);
      o.mem_color[t] = d.in.color;
      o.p_max_idx    = 2'(t);
      o.clusters_num = 2'((n < 3) ? n + 1 : 3);
    end else begin
      o.clusters_num = 2'(n);
    end
    for (int k = 0; k < 3; k++) o.mem_w[k] = 8'(w[k]);
    return o;
  endfunction

  function automatic mega_data_t rand_data();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    return mega_data_t'(t[$bits(mega_data_t)-1:0]);
  endfunction

  function automatic mega_data_t base_data();
    mega_data_t d;
    d = '0;
    d.in.color     = '{r: 8'd10, g: 8'd20, b: 8'd30};
    d.mem_var[0]   = 16'd111;
    d.mem_var[1]   = 16'd222;
    d.mem_var[2]   = 16'd333;
    d.mem_color[0] = '{r: 8'd1, g: 8'd2, b: 8'd3};
    d.mem_color[1] = '{r: 8'd4, g: 8'd5, b: 8'd6};
    d.mem_color[2] = '{r: 8'd7, g: 8'd8, b: 8'd9};
    d.clusters_num = 2'd1;
    d.b            = 2'd2;
    d.vars         = 16'hbeef;
    d.w_sum        = 10'd321;
    d.var_min      = 16'h1234;
    d.var_max      = 16'habcd;
    return d;
  endfunction

  // Hand-derived vectors; expected records start from the input and only the
  // fields the stage is meant to touch are edited.
  task automatic build_vectors();
    mega_data_t d, e;
    // N=3 matched p=1: {100,50,20} -> {94,63,19}
    d = base_data(); d.in.clusters_num = 2'd3; d.is_matched = 1'b1; d.p_max_idx = 2'd1;
    d.mem_w[0] = 8'd100; d.mem_w[1] = 8'd50; d.mem_w[2] = 8'd20;
    e = d; e.mem_w[0] = 8'd94; e.mem_w[1] = 8'd63; e.mem_w[2] = 8'd19; e.clusters_num = 2'd3;
    vecs[0] = '{din: d, dexp: e};
    // N=1 unmatched: w0 200 -> 188, slot 1 inserted, slot 2 untouched
    d = base_data(); d.in.clusters_num = 2'd1; d.is_matched = 1'b0; d.p_max_idx = 2'd3;
    d.mem_w[0] = 8'd200; d.mem_w[1] = 8'd5; d.mem_w[2] = 8'd77;
    e = d; e.mem_w[0] = 8'd188; e.mem_w[1] = 8'd16; e.mem_var[1] = 16'd900;
    e.mem_color[1] = '{r: 8'd10, g: 8'd20, b: 8'd30}; e.clusters_num = 2'd2; e.p_max_idx = 2'd1;
    vecs[1] = '{din: d, dexp: e};
    // N=3 unmatched, tie between slots 1 and 2 -> slot 2 replaced
    d = base_data(); d.in.clusters_num = 2'd3; d.is_matched = 1'b0; d.p_max_idx = 2'd0;
    d.mem_w[0] = 8'd40; d.mem_w[1] = 8'd8; d.mem_w[2] = 8'd8;
    e = d; e.mem_w[0] = 8'd38; e.mem_w[1] = 8'd8; e.mem_w[2] = 8'd16; e.mem_var[2] = 16'd900;
    e.mem_color[2] = '{r: 8'd10, g: 8'd20, b: 8'd30}; e.clusters_num = 2'd3; e.p_max_idx = 2'd2;
    vecs[2] = '{din: d, dexp: e};
    // N=2 matched p=1, w1=250 -> 251
    d = base_data(); d.in.clusters_num = 2'd2; d.is_matched = 1'b1; d.p_max_idx = 2'd1;
    d.mem_w[0] = 8'd0; d.mem_w[1] = 8'd250; d.mem_w[2] = 8'd44;
    e = d; e.mem_w[1] = 8'd251; e.clusters_num = 2'd2;
    vecs[3] = '{din: d, dexp: e};
    // N=2 matched p=1, w1=255 -> 240+16 saturates at 255; w0 16 -> 15
    d = base_data(); d.in.clusters_num = 2'd2; d.is_matched = 1'b1; d.p_max_idx = 2'd1;
    d.mem_w[0] = 8'd16; d.mem_w[1] = 8'd255; d.mem_w[2] = 8'd3;
    e = d; e.mem_w[0] = 8'd15; e.mem_w[1] = 8'd255; e.clusters_num = 2'd2;
    vecs[4] = '{din: d, dexp: e};
    // matched with N=0 behaves as a miss: slot 0 inserted, other slots untouched
    d = base_data(); d.in.clusters_num = 2'd0; d.is_matched = 1'b1; d.p_max_idx = 2'd2;
    d.mem_w[0] = 8'd99; d.mem_w[1] = 8'd99; d.mem_w[2] = 8'd99;
    e = d; e.mem_w[0] = 8'd16; e.mem_var[0] = 16'd900;
    e.mem_color[0] = '{r: 8'd10, g: 8'd20, b: 8'd30}; e.clusters_num = 2'd1; e.p_max_idx = 2'd0;
    vecs[5] = '{din: d, dexp: e};
    // matched with p >= N: decay only
    d = base_data(); d.in.clusters_num = 2'd2; d.is_matched = 1'b1; d.p_max_idx = 2'd3;
    d.mem_w[0] = 8'd64; d.mem_w[1] = 8'd33; d.mem_w[2] = 8'd120;
    e = d; e.mem_w[0] = 8'd60; e.mem_w[1] = 8'd31; e.clusters_num = 2'd2;
    vecs[6] = '{din: d, dexp: e};
  endtask

  // Send one beat into an empty pipe with src_ready high, check latency and data.
  task automatic run_vector(input int idx);
    int lat;
    @(negedge clk);
    snk_valid = 1'b1;
    snk_data  = vecs[idx].din;
    src_ready = 1'b1;
    #1;
    check_int($sformatf("vec%0d_snk_ready", idx), int'(snk_ready), 1);
    @(posedge clk);
    #1;
    snk_valid = 1'b0;
    lat = 1;
    while (!src_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_int($sformatf("vec%0d_latency", idx), lat, 3);
    check_data($sformatf("vec%0d_data", idx), src_data, vecs[idx].dexp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    mega_data_t q [$];
    mega_data_t exp_d, stall_d;
    bit have_stall, pending;
    int sent, recv, cyc, seen;

    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    snk_valid = 1'b0;
    snk_data = '0;
    src_ready = 1'b0;
    build_vectors();

    repeat (3) @(posedge clk);
    #1;
    check_int("reset_src_valid", int'(src_valid), 0);
    check_data("reset_src_data", src_data, '0);
    check_int("reset_snk_ready", int'(snk_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) run_vector(i);

    // Random valid/ready traffic against the reference queue.
    sent = 0; recv = 0; cyc = 0; have_stall = 0; pending = 0;
    while (recv < NBEATS && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (have_stall)
        check_data("stall_hold", src_valid ? src_data : ~stall_d, stall_d);
      if (!pending) begin
        snk_valid = (sent < NBEATS) && ($urandom_range(0, 3) != 0);
        if (snk_valid) snk_data = rand_data();
      end
      src_ready = ($urandom_range(0, 2) != 0);
      #1;
      pending = snk_valid && !snk_ready;
      if (snk_valid && snk_ready) begin
        q.push_back(model(snk_data));
        sent++;
      end
      if (src_valid && src_ready) begin
        if (q.size() == 0) begin
          check_int("unexpected_beat", 1, 0);
        end else begin
          exp_d = q.pop_front();
          check_data($sformatf("rand_beat%0d", recv), src_data, exp_d);
        end
        recv++;
      end
      have_stall = src_valid && !src_ready;
      stall_d    = src_data;
    end
    check_int("rand_beats_received", recv, NBEATS);
    check_int("rand_queue_empty", q.size(), 0);

    // Reset with three beats in flight.
    @(negedge clk);
    snk_valid = 1'b0;
    src_ready = 1'b0;
    repeat (4) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      snk_valid = 1'b1;
      snk_data  = vecs[i].din;
    end
    @(negedge clk);
    snk_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_int("midrst_src_valid", int'(src_valid), 0);
    check_int("midrst_snk_ready", int'(snk_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    src_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (src_valid) seen++;
    end
    check_int("midrst_no_stale", seen, 0);
    run_vector(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
